iic_master: RTL and testbench
=============================

IIC_MASTER -- requirements
Module: iic_master

Interface
REQ-001 SHALL have parameter SYS_CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter SCL_HZ, default 100_000, target SCL frequency in Hz.
REQ-003 SHALL have parameter ADDR_BYTES, default 1, word-address length in bytes (legal values 1 or 2).
REQ-004 SHALL have port clk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port srst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port start, input, 1, one-cycle transaction request; sampled only in IDLE.
REQ-007 SHALL have port rw, input, 1, direction: 0 = write, 1 = random read.
REQ-008 SHALL have port dev_addr, input, 7, slave device address.
REQ-009 SHALL have port word_addr, input, 16, word address; only the low 8 bits are used when ADDR_BYTES=1.
REQ-010 SHALL have port wdata, input, 8, write data byte.
REQ-011 SHALL have port rdata, output, 8, read data byte, held until the next read completes.
REQ-012 SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-013 SHALL have port done, output, 1, one-cycle pulse at end of a transaction.
REQ-014 SHALL have port ack_err, output, 1, set with done when any slave ACK was missing.
REQ-015 SHALL have port scl, output, 1, I2C clock.
REQ-016 SHALL have port sda_o, output, 1, SDA drive value; always 0 when driving (open-drain).
REQ-017 SHALL have port sda_oe, output, 1, SDA drive enable; 0 = released.
REQ-018 SHALL have port sda_i, input, 1, sampled SDA line.

Function
REQ-019 SHALL derive QDIV = SYS_CLK_HZ/(4*SCL_HZ) (integer) and generate one quarter-period tick every QDIV clocks while busy.
REQ-020 SHALL keep SCL high in IDLE and hold each SCL phase for exactly 2 ticks.
REQ-021 SHALL change SDA only while SCL is low, except for START and STOP conditions.
REQ-022 SHALL sample sda_i at the tick marking the middle of the SCL-high phase.
REQ-023 SHALL use states IDLE, START, DEVW, ACK1, ADDRH, ACK2, ADDRL, ACK3, WDATA, ACK4, RSTART, DEVR, ACK5, RDATA, MNACK, STOP, DONE.
REQ-024 SHALL skip ADDRH/ACK2 when ADDR_BYTES=1.
REQ-025 SHALL follow this write path: START, DEVW ({dev_addr,0}), ACK, address byte(s), ACK, WDATA, ACK, STOP, DONE.
REQ-026 SHALL follow this read path: START, DEVW, ACK, address byte(s), ACK, RSTART, DEVR ({dev_addr,1}), ACK5, RDATA, MNACK (master drives SDA high, i.e. released), STOP, DONE.
REQ-027 SHALL transmit bytes MSB first and shift RDATA MSB first, using a 3-bit bit counter that wraps 7 -> 0 on every byte.
REQ-028 SHALL, on sda_i=1 in any ACK state, set an internal nack flag and go directly to STOP.
REQ-029 SHALL, in DONE, pulse done for 1 cycle, set ack_err = nack flag, update rdata only on a successful read, then return to IDLE.
REQ-030 SHALL latch rw, dev_addr, word_addr and wdata on start acceptance; later input changes SHALL have no effect.
REQ-031 SHALL ignore start while busy (no queueing).
REQ-032 SHALL allow a start in the cycle after done to be accepted.

Reset
REQ-033 SHALL, on srst_n low (at any time, including mid-transfer), immediately force state=IDLE, scl=1, sda_oe=0, sda_o=0, busy=0, done=0, ack_err=0, rdata=8'h00, and clear the counters.
REQ-034 SHALL NOT issue a STOP condition for a transfer aborted by reset.

Structure
REQ-035 SHALL place the state enumeration and the R/W bit constants in shared package iic_pkg.
REQ-036 SHALL implement the quarter-tick generator as sub-module iic_clk_div (parameter QDIV; ports clk, srst_n, en, tick).

Verification
REQ-037 SHALL verify write: defaults, dev_addr=7'h50, word_addr=8'h1A, wdata=8'hA5, slave ACKs all bytes -> bus bytes A0,1A,A5, then STOP; done pulse with ack_err=0; SCL period = 500 clocks.
REQ-038 SHALL verify read: rw=1, dev_addr=7'h50, word_addr=8'h1A, slave returns 8'h3C -> bus bytes A0,1A, repeated START, A1; master NACK; rdata=8'h3C at done.
REQ-039 SHALL verify NACK: slave NACKs the device byte -> STOP follows immediately; ack_err=1; rdata unchanged.
REQ-040 SHALL verify two-byte address: ADDR_BYTES=2, word_addr=16'h0123 -> address bytes 01 then 23.
REQ-041 SHALL verify reset mid-transfer: srst_n low during WDATA -> scl=1, sda_oe=0, busy=0 within the same cycle; a new start after reset completes normally.
REQ-042 SHALL verify start while busy: start asserted during DEVW -> ignored; exactly one done pulse.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared types for the I2C EEPROM-style master.
// State encoding, R/W bit values and state-class helpers.
package iic_pkg;

  typedef enum logic [4:0] {
    IDLE,
    START,
    DEVW,
    ACK1,
    ADDRH,
    ACK2,
    ADDRL,
    ACK3,
    WDATA,
    ACK4,
    RSTART,
    DEVR,
    ACK5,
    RDATA,
    MNACK,
    STOP,
    DONE
  } state_t;

  localparam logic RW_WR = 1'b0;
  localparam logic RW_RD = 1'b1;

  function automatic logic is_tx(state_t s);
    return s inside {DEVW, ADDRH, ADDRL, WDATA, DEVR};
  endfunction

  function automatic logic is_byte(state_t s);
    return is_tx(s) || (s == RDATA);
  endfunction

  function automatic logic is_ack(state_t s);
    return s inside {ACK1, ACK2, ACK3, ACK4, ACK5};
  endfunction

endpackage

// File: rtl/iic_clk_div.sv
// Quarter-SCL-period tick generator.
// Counter is held clear while disabled so the first tick lands QDIV clocks in.
module iic_clk_div #(
  parameter int unsigned QDIV = 125
) (
  input  logic clk,
  input  logic srst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CW'(QDIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) cnt_d = '0;
    else cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end

endmodule

// File: rtl/iic_master.sv
// Single-byte I2C master: write or random read with 1/2-byte word address.
// Each bit is four quarter-ticks: SCL low, low, high, high.
module iic_master
  import iic_pkg::*;
#(
  parameter int unsigned SYS_CLK_HZ = 50_000_000,
  parameter int unsigned SCL_HZ     = 100_000,
  parameter int unsigned ADDR_BYTES = 1
) (
  input  logic        clk,
  input  logic        srst_n,
  input  logic        start,
  input  logic        rw,
  input  logic [6:0]  dev_addr,
  input  logic [15:0] word_addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl,
  output logic        sda_o,
  output logic        sda_oe,
  input  logic        sda_i
);

  localparam int unsigned QDIV = SYS_CLK_HZ / (4 * SCL_HZ);

  state_t      state_q, state_d, nxt;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic        sda_oe_q, sda_oe_d;
  logic        nack_q, nack_d;
  logic        rw_q, rw_d;
  logic        ack_err_q, ack_err_d;
  logic [6:0]  dev_q, dev_d;
  logic [15:0] wa_q, wa_d;
  logic [7:0]  wd_q, wd_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [7:0]  tx;
  logic        en, tick;

  assign en = (state_q != IDLE);

  iic_clk_div #(.QDIV(QDIV)) u_div (
    .clk    (clk),
    .srst_n (srst_n),
    .en     (en),
    .tick   (tick)
  );

  always_comb begin
    tx = 8'h00;
    unique case (1'b1)
      state_q == DEVW:  tx = {dev_q, RW_WR};
      state_q == ADDRH: tx = wa_q[15:8];
      state_q == ADDRL: tx = wa_q[7:0];
      state_q == WDATA: tx = wd_q;
      state_q == DEVR:  tx = {dev_q, RW_RD};
      default:          tx = 8'h00;
    endcase
  end

  always_comb begin
    nxt = state_q;
    unique case (state_q)
      START:   nxt = DEVW;
      DEVW:    nxt = ACK1;
      ACK1:    nxt = nack_q ? STOP : ((ADDR_BYTES == 2) ? ADDRH : ADDRL);
      ADDRH:   nxt = ACK2;
      ACK2:    nxt = nack_q ? STOP : ADDRL;
      ADDRL:   nxt = ACK3;
      ACK3:    nxt = nack_q ? STOP : ((rw_q == RW_RD) ? RSTART : WDATA);
      WDATA:   nxt = ACK4;
      ACK4:    nxt = STOP;
      RSTART:  nxt = DEVR;
      DEVR:    nxt = ACK5;
      ACK5:    nxt = nack_q ? STOP : RDATA;
      RDATA:   nxt = MNACK;
      MNACK:   nxt = STOP;
      STOP:    nxt = DONE;
      default: nxt = state_q;
    endcase
  end

  // SDA data moves mid-low; START/STOP edges are placed mid-high.
  always_comb begin
    state_d   = state_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    sda_oe_d  = sda_oe_q;
    nack_d    = nack_q;
    rw_d      = rw_q;
    dev_d     = dev_q;
    wa_d      = wa_q;
    wd_d      = wd_q;
    rx_d      = rx_q;
    rdata_d   = rdata_q;
    ack_err_d = ack_err_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d   = START;
        qtr_d     = 2'd0;
        bit_d     = 3'd0;
        sda_oe_d  = 1'b0;
        nack_d    = 1'b0;
        ack_err_d = 1'b0;
        rw_d      = rw;
        dev_d     = dev_addr;
        wa_d      = word_addr;
        wd_d      = wdata;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end else if (tick) begin
      qtr_d = qtr_q + 2'd1;
      unique case (qtr_q)
        2'd0: sda_oe_d = is_tx(state_q) ? ~tx[~bit_q] : (state_q == STOP);
        2'd1: if (state_q == START) sda_oe_d = 1'b1;
        2'd2: begin
          if (state_q == RSTART) sda_oe_d = 1'b1;
          if (state_q == STOP) sda_oe_d = 1'b0;
          if (is_ack(state_q) && sda_i) nack_d = 1'b1;
          if (state_q == RDATA) rx_d = {rx_q[6:0], sda_i};
        end
        2'd3: begin
          if (is_byte(state_q)) bit_d = bit_q + 3'd1;
          if (!is_byte(state_q) || bit_q == 3'd7) state_d = nxt;
          if (state_q == STOP) begin
            ack_err_d = nack_q;
            if (rw_q == RW_RD && !nack_q) rdata_d = rx_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q   <= IDLE;
      qtr_q     <= 2'd0;
      bit_q     <= 3'd0;
      sda_oe_q  <= 1'b0;
      nack_q    <= 1'b0;
      rw_q      <= 1'b0;
      dev_q     <= 7'h00;
      wa_q      <= 16'h0000;
      wd_q      <= 8'h00;
      rx_q      <= 8'h00;
      rdata_q   <= 8'h00;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      sda_oe_q  <= sda_oe_d;
      nack_q    <= nack_d;
      rw_q      <= rw_d;
      dev_q     <= dev_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
      rx_q      <= rx_d;
      rdata_q   <= rdata_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign scl     = (state_q inside {IDLE, START, DONE}) ? 1'b1 : qtr_q[1];
  assign sda_o   = 1'b0;
  assign sda_oe  = sda_oe_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign ack_err = ack_err_q;
  assign rdata   = rdata_q;

endmodule

// File: tb/tb_iic_master.sv
// Bench for iic_master: bus-level slave model and token-list reference.
// Instance A uses default timing, instance B a fast clock with 2-byte addresses.
module tb_iic_master;

  localparam int T_S  = 256;
  localparam int T_RS = 257;
  localparam int T_P  = 258;
  localparam int PH_RX   = 0;
  localparam int PH_SACK = 1;
  localparam int PH_TX   = 2;
  localparam int PH_MACK = 3;
  localparam int PH_HOLD = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst_n;
  logic        start_a, start_b;
  logic        rw;
  logic [6:0]  dev_addr;
  logic [15:0] word_addr;
  logic [7:0]  wdata;

  logic [7:0] rdata_a, rdata_b;
  logic busy_a, done_a, ack_err_a, scl_a, sda_o_a, sda_oe_a;
  logic busy_b, done_b, ack_err_b, scl_b, sda_o_b, sda_oe_b;
  logic sda_a_i, sda_b_i, scl_m, line;
  logic sel;
  logic slave_low;

  assign sda_a_i = !(sda_oe_a || (!sel && slave_low));
  assign sda_b_i = !(sda_oe_b || (sel && slave_low));
  assign scl_m   = sel ? scl_b : scl_a;
  assign line    = sel ? sda_b_i : sda_a_i;

  iic_master u_a (
    .clk(clk), .srst_n(srst_n), .start(start_a), .rw(rw),
    .dev_addr(dev_addr), .word_addr(word_addr), .wdata(wdata),
    .rdata(rdata_a), .busy(busy_a), .done(done_a), .ack_err(ack_err_a),
    .scl(scl_a), .sda_o(sda_o_a), .sda_oe(sda_oe_a), .sda_i(sda_a_i)
  );

  iic_master #(
    .SYS_CLK_HZ(1_600_000), .SCL_HZ(100_000), .ADDR_BYTES(2)
  ) u_b (
    .clk(clk), .srst_n(srst_n), .start(start_b), .rw(rw),
    .dev_addr(dev_addr), .word_addr(word_addr), .wdata(wdata),
    .rdata(rdata_b), .busy(busy_b), .done(done_b), .ack_err(ack_err_b),
    .scl(scl_b), .sda_o(sda_o_b), .sda_oe(sda_oe_b), .sda_i(sda_b_i)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Slave model state
  int toks[$];
  int exp_toks[$];
  int nack_idx;
  logic [7:0] rd_val;
  int clr_req = 0, clr_ack = 0;
  int phase = PH_HOLD, bitn = 0, nbytes = 0;
  int cyc = 0, last_rise = 0, scl_per = 0;
  logic in_txn = 1'b0, first = 1'b0, to_tx = 1'b0, mack = 1'b0;
  logic scl_p = 1'b1, sda_p = 1'b1;
  logic [7:0] sh = 8'h00;
  int done_cnt_a = 0, done_cnt_b = 0;

  always @(negedge clk) begin
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
  end

  always @(negedge clk) begin
    cyc++;
    if (clr_req != clr_ack) begin
      clr_ack = clr_req;
      toks.delete();
      in_txn = 1'b0; phase = PH_HOLD; bitn = 0; nbytes = 0;
      slave_low = 1'b0; mack = 1'b0;
    end else if (scl_m && scl_p && sda_p && !line) begin
      toks.push_back(in_txn ? T_RS : T_S);
      in_txn = 1'b1; phase = PH_RX; bitn = 0; first = 1'b1;
      slave_low = 1'b0;
    end else if (scl_m && scl_p && !sda_p && line) begin
      toks.push_back(T_P);
      in_txn = 1'b0; phase = PH_HOLD; slave_low = 1'b0;
    end else if (scl_m && !scl_p) begin
      if (phase == PH_RX) begin
        if (bitn > 0) scl_per = cyc - last_rise;
        sh = {sh[6:0], line};
        bitn++;
        if (bitn == 8) toks.push_back(int'(sh));
      end else if (phase == PH_TX) begin
        bitn++;
      end else if (phase == PH_MACK) begin
        mack = line;
      end
      last_rise = cyc;
    end else if (!scl_m && scl_p) begin
      case (phase)
        PH_RX: if (bitn == 8) begin
          phase = PH_SACK;
          slave_low = (nbytes != nack_idx);
          to_tx = first && sh[0] && slave_low;
          nbytes++;
          first = 1'b0;
        end
        PH_SACK: begin
          bitn = 0;
          if (to_tx) begin
            phase = PH_TX; slave_low = !rd_val[7];
          end else begin
            phase = PH_RX; slave_low = 1'b0;
          end
        end
        PH_TX: if (bitn == 8) begin
          phase = PH_MACK; slave_low = 1'b0;
        end else begin
          slave_low = !rd_val[7-bitn];
        end
        PH_MACK: begin
          phase = PH_HOLD; slave_low = 1'b0;
        end
        default: ;
      endcase
    end
    scl_p = scl_m;
    sda_p = line;
  end

  // Reference: the sequence of bus events the transfer should produce.
  function automatic void build_exp(input logic rw_, input logic [6:0] dev,
      input logic [15:0] wa, input logic [7:0] wd, input int ab,
      input int nidx);
    int seq[$];
    int n;
    seq.push_back(T_S);
    seq.push_back(int'({dev, 1'b0}));
    if (ab == 2) seq.push_back(int'(wa[15:8]));
    seq.push_back(int'(wa[7:0]));
    if (rw_) begin
      seq.push_back(T_RS);
      seq.push_back(int'({dev, 1'b1}));
    end else begin
      seq.push_back(int'(wd));
    end
    exp_toks.delete();
    n = 0;
    foreach (seq[i]) begin
      exp_toks.push_back(seq[i]);
      if (seq[i] < 256) begin
        if (n == nidx) break;
        n++;
      end
    end
    exp_toks.push_back(T_P);
  endfunction

  logic [7:0] rmodel [2];

  task automatic run_txn(input logic s, input logic rw_,
      input logic [6:0] dev, input logic [15:0] wa, input logic [7:0] wd,
      input int nidx, input logic [7:0] rv, input logic spam);
    int dc0, spam_at;
    logic got_done, ae, exp_ae;
    logic [7:0] rd;
    got_done = 1'b0; ae = 1'b0; rd = 8'h00;
    sel = s; nack_idx = nidx; rd_val = rv;
    clr_req++;
    repeat (2) @(negedge clk);
    build_exp(rw_, dev, wa, wd, s ? 2 : 1, nidx);
    exp_ae = (nidx >= 0);
    rw = rw_; dev_addr = dev; word_addr = wa; wdata = wd;
    dc0 = s ? done_cnt_b : done_cnt_a;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    chk("busy_up", s ? busy_b : busy_a, 1);
    rw = 1'($urandom); dev_addr = 7'($urandom);
    word_addr = 16'($urandom); wdata = 8'($urandom);
    spam_at = $urandom_range(20, 100);
    for (int i = 0; i < 40000 && !got_done; i++) begin
      @(negedge clk);
      if (s) start_b = spam && (i == spam_at);
      else start_a = spam && (i == spam_at);
      if (s ? done_b : done_a) begin
        got_done = 1'b1;
        ae = s ? ack_err_b : ack_err_a;
        rd = s ? rdata_b : rdata_a;
      end
    end
    start_a = 1'b0; start_b = 1'b0;
    chk("done_seen", got_done, 1);
    chk("ack_err", ae, exp_ae);
    if (rw_ && !exp_ae) rmodel[s] = rv;
    chk("rdata", rd, rmodel[s]);
    repeat (60) @(negedge clk);
    chk("one_done", (s ? done_cnt_b : done_cnt_a) - dc0, 1);
    chk("busy_idle", s ? busy_b : busy_a, 0);
    chk("ntok", toks.size(), exp_toks.size());
    foreach (exp_toks[i])
      chk("tok", (i < toks.size()) ? toks[i] : -1, exp_toks[i]);
    if (rw_ && !exp_ae) chk("mnack", mack, 1);
  endtask

  initial begin
    int dc0;
    logic reached;
    srst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    rw = 1'b0; dev_addr = 7'h00; word_addr = 16'h0; wdata = 8'h00;
    sel = 1'b0; nack_idx = -1; rd_val = 8'h00;
    rmodel[0] = 8'h00; rmodel[1] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl_a, 1);
    chk("rst_oe", sda_oe_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_aerr", ack_err_a, 0);
    chk("rst_rdata", rdata_a, 8'h00);
    srst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_txn(1'b0, 1'b0, 7'h50, 16'h001A, 8'hA5, -1, 8'h00, 1'b1);
    chk("scl_period", scl_per, 500);
    run_txn(1'b0, 1'b1, 7'h50, 16'h001A, 8'h00, -1, 8'h3C, 1'b0);
    run_txn(1'b0, 1'b0, 7'h50, 16'h001A, 8'hA5, 0, 8'h00, 1'b0);
    run_txn(1'b1, 1'b0, 7'h29, 16'h0123, 8'h5E, -1, 8'h00, 1'b1);

    for (int k = 0; k < 12; k++) begin
      logic r;
      int ni;
      r = 1'($urandom_range(0, 1));
      ni = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      run_txn(1'b1, r, 7'($urandom), 16'($urandom), 8'($urandom),
              ni, 8'($urandom), 1'($urandom));
    end

    // Abort a write during its data byte
    sel = 1'b1; nack_idx = -1; clr_req++;
    repeat (2) @(negedge clk);
    rw = 1'b0; dev_addr = 7'h11; word_addr = 16'h4455; wdata = 8'h66;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      @(negedge clk);
      reached = (toks.size() >= 4);
    end
    chk("reach_wdata", reached, 1);
    repeat (40) @(negedge clk);
    dc0 = done_cnt_b;
    srst_n = 1'b0;
    #1;
    chk("abort_scl", scl_b, 1);
    chk("abort_oe", sda_oe_b, 0);
    chk("abort_busy", busy_b, 0);
    chk("abort_done", done_b, 0);
    chk("abort_rdata", rdata_a, 8'h00);
    rmodel[0] = 8'h00; rmodel[1] = 8'h00;
    repeat (3) @(negedge clk);
    srst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_nodone", done_cnt_b - dc0, 0);
    chk("abort_idle", busy_b, 0);
    run_txn(1'b1, 1'b1, 7'h3A, 16'hBEEF, 8'h00, -1, 8'hC3, 1'b0);
    chk("sda_o_a", sda_o_a, 0);
    chk("sda_o_b", sda_o_b, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
